// File: rtl/spi_receiver.sv
// SPI mode-0 slave receiver: oversamples sclk/sdi/cs on the local clock,
// assembles MSB-first words, pulses valid per completed word and
// frame_error when cs rises on a partial word.
module spi_receiver #(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sclk,
    input  logic                  sdi,
    input  logic                  cs,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  valid,
    output logic                  frame_error,
    output logic                  active,
    output logic [7:0]            byte_count
);
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic {IDLE = 1'b0, RECEIVE = 1'b1} state_t;

    // Equal-depth chains keep sclk, sdi and cs aligned after synchronisation.
    logic [SYNC_STAGES-1:0] sclk_sync, sdi_sync, cs_sync;
    logic                   sclk_d;
    logic                   sclk_s, sdi_s, cs_s, rise;

    state_t                 state, state_nx;
    logic [CW-1:0]          bit_cnt, bit_cnt_nx;
    logic [DATA_WIDTH-1:0]  shift_q, shift_nx;
    logic [DATA_WIDTH-1:0]  data_nx;
    logic                   valid_nx, ferr_nx;
    logic [7:0]             bcnt_nx;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign sdi_s  = sdi_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_d;

    // Synchronizer chains; cs resets high so no phantom frame follows reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            sdi_sync  <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            sclk_d    <= sclk_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
            active      <= 1'b0;
            byte_count  <= '0;
        end else begin
            state       <= state_nx;
            bit_cnt     <= bit_cnt_nx;
            shift_q     <= shift_nx;
            data        <= data_nx;
            valid       <= valid_nx;
            frame_error <= ferr_nx;
            active      <= (state_nx == RECEIVE);
            byte_count  <= bcnt_nx;
        end
    end

    // Next-state logic; cs deassertion takes priority over a coincident rise.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift_q;
        data_nx    = data;
        valid_nx   = 1'b0;
        ferr_nx    = 1'b0;
        bcnt_nx    = byte_count;
        case (state)
            IDLE: begin
                if (!cs_s) begin
                    state_nx   = RECEIVE;
                    bit_cnt_nx = '0;
                    bcnt_nx    = '0;
                end
            end
            RECEIVE: begin
                if (cs_s) begin
                    ferr_nx    = (bit_cnt != '0);
                    state_nx   = IDLE;
                    bit_cnt_nx = '0;
                end else if (rise) begin
                    shift_nx = {shift_q[DATA_WIDTH-2:0], sdi_s};
                    if (bit_cnt == CW'(DATA_WIDTH - 1)) begin
                        data_nx    = shift_nx;
                        valid_nx   = 1'b1;
                        bit_cnt_nx = '0;
                        if (byte_count != 8'hFF)
                            bcnt_nx = byte_count + 8'd1;
                    end else begin
                        bit_cnt_nx = bit_cnt + CW'(1);
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_receiver.sv
// Scoreboard bench for spi_receiver: a bit-level SPI master drives frames,
// a frame model predicts words/counts/errors, a monitor checks outputs.
module tb_spi_receiver;
    localparam int DW   = 8;
    localparam int SYNC = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          sclk  = 1'b0;
    logic          sdi   = 1'b0;
    logic          cs    = 1'b1;
    logic [DW-1:0] data;
    logic          valid, frame_error, active;
    logic [7:0]    byte_count;

    spi_receiver #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
        .clock(clock), .reset(reset), .sclk(sclk), .sdi(sdi), .cs(cs),
        .data(data), .valid(valid), .frame_error(frame_error),
        .active(active), .byte_count(byte_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_d_q[$];
    logic [7:0] exp_c_q[$];
    int         rise_q[$];
    int         ferr_exp = 0;
    bit         fq[$];
    logic [7:0] last_data = 8'h00;
    logic [7:0] last_cnt  = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push_word(input logic [7:0] w);
        for (int j = DW - 1; j >= 0; j--) fq.push_back(w[j]);
    endtask

    // Model a frame from its bit list, then drive it with random phase lengths.
    task automatic run_frame(input int hmin, input int hmax);
        int nb, nw, h;
        logic [7:0] word;
        nb = fq.size();
        nw = nb / DW;
        for (int w = 0; w < nw; w++) begin
            word = 8'h00;
            for (int j = 0; j < DW; j++) word = 8'((word * 2) + fq[w * DW + j]);
            exp_d_q.push_back(word);
            exp_c_q.push_back((w + 1 > 255) ? 8'd255 : 8'(w + 1));
            last_data = word;
        end
        if (nb % DW != 0) ferr_exp++;
        last_cnt = (nw > 255) ? 8'd255 : 8'(nw);

        cs = 1'b0;
        tick($urandom_range(3, 1));
        for (int i = 0; i < nb; i++) begin
            h = $urandom_range(hmax, hmin);
            sdi = fq[i];
            tick(h);
            sclk = 1'b1;
            if (i % DW == DW - 1) rise_q.push_back(cyc);
            tick(h);
            sclk = 1'b0;
            if (i == 0) chk("active_in_frame", active, 1);
        end
        tick($urandom_range(2, 1));
        cs = 1'b1;
        tick(SYNC + 5);
        fq.delete();
        chk("active_idle", active, 0);
        chk("byte_count_hold", byte_count, last_cnt);
        chk("data_hold", data, last_data);
        chk("drain_valid", exp_d_q.size(), 0);
        chk("drain_frame_error", ferr_exp, 0);
    endtask

    // Monitor: pops expectations whenever the DUT presents valid or frame_error.
    initial begin
        logic [7:0] ed, ec;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (valid && frame_error) chk("valid_ferr_exclusive", 1, 0);
                if (valid) begin
                    chk("valid_expected", exp_d_q.size() > 0, 1);
                    if (exp_d_q.size() > 0) begin
                        ed = exp_d_q.pop_front();
                        ec = exp_c_q.pop_front();
                        chk("data", data, ed);
                        chk("byte_count", byte_count, ec);
                        chk("rise_recorded", rise_q.size() > 0, 1);
                        if (rise_q.size() > 0) chk("latency", cyc - rise_q.pop_front(), SYNC + 1);
                    end
                end
                if (frame_error) begin
                    chk("frame_error_expected", ferr_exp > 0, 1);
                    if (ferr_exp > 0) ferr_exp--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] w, bc_before;
        int nw, nx;

        // Reset state
        tick(3);
        chk("rst_data", data, 0);
        chk("rst_valid", valid, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_active", active, 0);
        chk("rst_byte_count", byte_count, 0);
        reset = 1'b0;
        tick(4);
        chk("idle_active", active, 0);

        // Single word
        push_word(8'hA5);
        run_frame(1, 3);

        // Back-to-back words in one frame
        push_word(8'h13); push_word(8'h26); push_word(8'h39);
        run_frame(1, 3);

        // Truncated frame, then a clean one
        fq.push_back(1'b1); fq.push_back(1'b0); fq.push_back(1'b1);
        run_frame(1, 2);
        push_word(8'h5A);
        run_frame(1, 2);

        // sclk noise with cs high
        bc_before = byte_count;
        repeat (20) begin
            sdi = 1'($urandom);
            tick(1);
            sclk = 1'b1;
            tick(1);
            sclk = 1'b0;
        end
        tick(SYNC + 3);
        chk("noise_active", active, 0);
        chk("noise_byte_count", byte_count, bc_before);
        chk("noise_data", data, last_data);

        // Reset mid-word
        cs = 1'b0;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            sdi = 1'b1; tick(1); sclk = 1'b1; tick(1); sclk = 1'b0;
        end
        reset = 1'b1;
        tick(1);
        chk("midrst_data", data, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_frame_error", frame_error, 0);
        chk("midrst_active", active, 0);
        chk("midrst_byte_count", byte_count, 0);
        cs = 1'b1;
        sdi = 1'b0;
        tick(2);
        reset = 1'b0;
        last_data = 8'h00;
        tick(SYNC + 3);
        chk("postrst_active", active, 0);
        push_word(8'h81);
        run_frame(1, 3);

        // Randomized frames, some truncated
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(4, 0);
            nx = $urandom_range(7, 0);
            for (int k = 0; k < nw; k++) push_word(8'($urandom));
            for (int k = 0; k < nx; k++) fq.push_back(1'($urandom));
            run_frame(1, 3);
        end

        // Loopback at full rate: 0x00, 0x13, ... step 19 through 0xFF
        w = 8'h00;
        forever begin
            push_word(w);
            if (w == 8'hFF) break;
            w = w + 8'd19;
        end
        run_frame(1, 1);

        // byte_count saturation
        for (int k = 0; k < 260; k++) push_word(8'($urandom));
        run_frame(1, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
